// File: rtl/machine_seg_pkg.sv
// Shared definitions for the multiplexed 7-segment scanner.
//   SEG_TABLE : 16-entry active-high hex glyph table, bits 6:0 = g..a
//   SEG_A..SEG_G, SEG_DP : bit positions in the 8-bit segment bus
//   seg_state_e : per-slot scan phase (dead time / lit)
package machine_seg_pkg;

    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    // Index 15 first: F, E, d, C, b, A, 9 ... 0
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } seg_state_e;

endpackage

// File: rtl/machine_hex_to_seg.sv
// Combinational hex nibble to active-high 7-segment glyph.
//   i_nibble : hex digit 0..F
//   o_seg    : glyph, bits 6:0 = g,f,e,d,c,b,a (active-high)
module machine_hex_to_seg
    import machine_seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_TABLE[i_nibble];
    end

endmodule

// File: rtl/machine_seg_scan.sv
// Multiplexed 7-segment scanner with double-buffered, frame-synchronous
// update, dead time between digits, per-digit enable/dp and leading-zero
// suppression.
//   clk, rst   : clock, async active-high reset
//   value      : 4*DIGITS hex digits, digit 0 in the low nibble
//   dp         : per-digit decimal point request
//   digit_en   : per-digit enable (0 = segments and dp dark)
//   lz_blank   : leading-zero suppression enable, captured with load
//   load       : strobe capturing value/dp/digit_en/lz_blank
//   seg        : {dp,g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//   anode      : one-hot digit select, polarity per AN_ACTIVE_LOW
//   digit_idx  : digit in the current slot
//   frame_tick : high on the last cycle of each frame
module machine_seg_scan
    import machine_seg_pkg::*;
#(
    parameter  int unsigned DIGITS         = 4,
    parameter  int unsigned CLK_DIV        = 50000,
    parameter  int unsigned BLANK_CYCLES   = 64,
    parameter  bit          SEG_ACTIVE_LOW = 1'b1,
    parameter  bit          AN_ACTIVE_LOW  = 1'b1,
    localparam int unsigned IDX_W          = (DIGITS > 1) ? $clog2(DIGITS) : 1
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic                  lz_blank,
    input  logic                  load,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     anode,
    output logic [IDX_W-1:0]      digit_idx,
    output logic                  frame_tick
);

    localparam int unsigned CNT_W     = $clog2(CLK_DIV);
    localparam bit          HAS_BLANK = (BLANK_CYCLES > 0);
    localparam logic [7:0]  SEG_OFF   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] AN_OFF = {DIGITS{AN_ACTIVE_LOW}};

    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    seg_state_e          r_state;
    logic [7:0]          r_seg;
    logic [DIGITS-1:0]   r_anode;

    logic [4*DIGITS-1:0] r_pend_val, r_act_val;
    logic [DIGITS-1:0]   r_pend_dp,  r_act_dp;
    logic [DIGITS-1:0]   r_pend_en,  r_act_en;
    logic                r_pend_lz,  r_act_lz;

    logic                w_slot_end;
    logic                w_tick;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [IDX_W-1:0]    w_idx_nxt;
    seg_state_e          w_state_nxt;

    logic [4*DIGITS-1:0] w_act_val_nxt;
    logic [DIGITS-1:0]   w_act_dp_nxt;
    logic [DIGITS-1:0]   w_act_en_nxt;
    logic                w_act_lz_nxt;

    logic [3:0]          w_nib;
    logic                w_dp_bit;
    logic                w_en_bit;
    logic                w_sup;
    logic                w_allz;
    logic [6:0]          w_hex;
    logic [7:0]          w_pat;
    logic [DIGITS-1:0]   w_an_hot;
    logic [7:0]          w_seg_drv;
    logic [DIGITS-1:0]   w_an_drv;

    // Scan timing and double-buffer commit. Everything below is computed
    // for the upcoming cycle so the registered outputs line up with r_cnt.
    always_comb begin
        w_slot_end = (r_cnt == CNT_W'(CLK_DIV - 1));
        w_tick     = w_slot_end && (r_idx == IDX_W'(DIGITS - 1));
        w_cnt_nxt  = w_slot_end ? '0 : r_cnt + 1'b1;

        w_idx_nxt = r_idx;
        if (w_slot_end) begin
            w_idx_nxt = (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end

        w_state_nxt = r_state;
        case (r_state)
            BLANK:   if (!HAS_BLANK || w_cnt_nxt == CNT_W'(BLANK_CYCLES)) w_state_nxt = SHOW;
            SHOW:    if (HAS_BLANK && w_cnt_nxt == '0)                    w_state_nxt = BLANK;
            default: w_state_nxt = BLANK;
        endcase

        // A load coinciding with the frame tick bypasses the pending set
        w_act_val_nxt = r_act_val;
        w_act_dp_nxt  = r_act_dp;
        w_act_en_nxt  = r_act_en;
        w_act_lz_nxt  = r_act_lz;
        if (w_tick) begin
            w_act_val_nxt = load ? value    : r_pend_val;
            w_act_dp_nxt  = load ? dp       : r_pend_dp;
            w_act_en_nxt  = load ? digit_en : r_pend_en;
            w_act_lz_nxt  = load ? lz_blank : r_pend_lz;
        end
    end

    // Digit select plus leading-zero scan from the most significant digit down
    always_comb begin
        w_nib    = '0;
        w_dp_bit = 1'b0;
        w_en_bit = 1'b0;
        w_sup    = 1'b0;
        w_allz   = 1'b1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            w_allz = w_allz && (w_act_val_nxt[4*(DIGITS-1-k) +: 4] == 4'h0);
            if (IDX_W'(DIGITS - 1 - k) == w_idx_nxt) begin
                w_nib    = w_act_val_nxt[4*(DIGITS-1-k) +: 4];
                w_dp_bit = w_act_dp_nxt[DIGITS-1-k];
                w_en_bit = w_act_en_nxt[DIGITS-1-k];
                w_sup    = w_act_lz_nxt && (k != DIGITS - 1) && w_allz;
            end
        end
    end

    machine_hex_to_seg u_hex (
        .i_nibble (w_nib),
        .o_seg    (w_hex)
    );

    always_comb begin
        w_pat = '0;
        if (w_state_nxt == SHOW && w_en_bit) begin
            w_pat[SEG_DP] = w_dp_bit;
            if (!w_sup) begin
                w_pat[SEG_G:SEG_A] = w_hex;
            end
        end
        w_an_hot  = (w_state_nxt == SHOW) ? (DIGITS'(1) << w_idx_nxt) : '0;
        w_seg_drv = SEG_ACTIVE_LOW ? ~w_pat : w_pat;
        w_an_drv  = AN_ACTIVE_LOW ? ~w_an_hot : w_an_hot;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_state    <= BLANK;
            r_seg      <= SEG_OFF;
            r_anode    <= AN_OFF;
            r_pend_val <= '0;
            r_pend_dp  <= '0;
            r_pend_en  <= '0;
            r_pend_lz  <= 1'b0;
            r_act_val  <= '0;
            r_act_dp   <= '0;
            r_act_en   <= '0;
            r_act_lz   <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_state   <= w_state_nxt;
            r_seg     <= w_seg_drv;
            r_anode   <= w_an_drv;
            r_act_val <= w_act_val_nxt;
            r_act_dp  <= w_act_dp_nxt;
            r_act_en  <= w_act_en_nxt;
            r_act_lz  <= w_act_lz_nxt;
            if (load) begin
                r_pend_val <= value;
                r_pend_dp  <= dp;
                r_pend_en  <= digit_en;
                r_pend_lz  <= lz_blank;
            end
        end
    end

    assign seg        = r_seg;
    assign anode      = r_anode;
    assign digit_idx  = r_idx;
    assign frame_tick = w_tick;

endmodule

// File: doc/machine_seg_scan.md
Name: machine_seg_scan

Overview:
Parametrised multiplexed 7-segment display driver. Scans DIGITS hex digits onto one shared segment bus with one-hot anode selects. Adds per-digit decimal points, per-digit enables, leading-zero suppression, anti-ghosting dead time and tear-free frame-synchronous update. Sits between core status registers and the board display pins, superseding direct per-digit nibble decoding.

Parameters:
DIGITS, 4, number of digits scanned (1..16)
CLK_DIV, 50000, clock cycles per digit slot (>= 2)
BLANK_CYCLES, 64, dead-time cycles at start of each slot with all anodes off (0 <= BLANK_CYCLES < CLK_DIV)
SEG_ACTIVE_LOW, 1, 1 = segment outputs active-low
AN_ACTIVE_LOW, 1, 1 = anode outputs active-low

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
value  in  4*DIGITS  hex digits; digit i = value[4i+3:4i]; digit 0 is least significant
dp  in  DIGITS  decimal point request per digit
digit_en  in  DIGITS  per-digit enable; 0 = digit dark (segments and dp off)
lz_blank  in  1  leading-zero suppression enable; sampled with load
load  in  1  one-cycle strobe capturing value/dp/digit_en/lz_blank
seg  out  8  bit 7 = dp, bits 6:0 = g,f,e,d,c,b,a; polarity per SEG_ACTIVE_LOW
anode  out  DIGITS  one-hot digit select; polarity per AN_ACTIVE_LOW
digit_idx  out  clog2(DIGITS) (min 1)  index of digit in current slot
frame_tick  out  1  one-cycle pulse on last cycle of each frame

Behaviour:
- Reset (async assert, sync release): all anodes inactive, seg all-off (8'hFF when active-low), digit_idx=0, frame_tick=0, slot counter=0, FSM=BLANK. Pending and active registers cleared: value=0, dp=0, digit_en=0, lz=0. Display stays dark until first commit.
- Slot counter counts 0..CLK_DIV-1, then wraps to 0 and advances digit_idx. digit_idx wraps from DIGITS-1 to 0.
- FSM per slot: BLANK for counts 0..BLANK_CYCLES-1, SHOW for counts BLANK_CYCLES..CLK_DIV-1. BLANK_CYCLES=0 gives no BLANK state.
- Outputs are registered from FSM state. During BLANK, anodes are inactive and seg is all-off. During SHOW, exactly one anode (digit_idx) is active and seg carries that digit's pattern.
- Frame = DIGITS*CLK_DIV cycles. frame_tick=1 during the cycle where counter=CLK_DIV-1 and digit_idx=DIGITS-1.
- Double buffering: load writes the pending register set. The active register set copies pending at the frame_tick edge only. Mid-frame loads never alter the displayed frame.
- Multiple loads before a commit: last one wins. load asserted in the frame_tick cycle: the incoming data commits directly (bypasses pending).
- Decode: standard hex table, 0-9 and A,b,C,d,E,F. Active-high patterns: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71. Inverted when SEG_ACTIVE_LOW=1.
- Leading-zero suppression (active lz=1): a digit i>0 is suppressed if it and all higher digits are 0. Digit 0 is never suppressed. A suppressed digit shows g..a off, and its dp is still honoured.
- Disabled digit (digit_en=0): g..a and dp all off. Its anode still activates in SHOW, and slot timing is unchanged.
- rst asserted mid-frame: immediate return to reset values. Any pending load is lost.

Decomposition:
- Package machine_seg_pkg: 16-entry active-high segment table constant, segment bit-position constants (SEG_A..SEG_G, SEG_DP), FSM state enum {BLANK, SHOW}.
- Sub-module machine_hex_to_seg: combinational nibble -> 7-bit active-high pattern from the package table. Polarity, dp and blanking are applied in the top level.

Test Plan (DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2, both polarities active-low unless noted):
- Reset: hold rst, then release. Required: anode=4'b1111 and seg=8'hFF. First frame_tick at cycle 31 after release, then every 32 cycles. Display stays dark.
- Load value=16'h12AF, dp=0, digit_en=4'hF. After next frame_tick, per slot: 2 blank cycles (anode=1111, seg=FF), then 6 cycles anode=1110 seg=8E (F), 1101 seg=88 (A), 1011 seg=A4 (2), 0111 seg=F9 (1).
- Tear-free update: load 16'h0000 mid-frame. Current frame still shows 12AF. Next frame shows C0 on all digits.
- Leading-zero suppression: value=16'h0050, lz_blank=1, dp=4'b1000. Required: digit0 C0, digit1 92, digit2 FF, digit3 7F (dp only). Repeat with lz_blank=0: digit2 C0, digit3 40.
- Enables and polarity: digit_en=4'b0101, SEG_ACTIVE_LOW=0, AN_ACTIVE_LOW=0, value=16'h8888. Required: digits 0 and 2 seg=7F with anode one-hot high; digits 1 and 3 seg=00.
- Simultaneous and async cases: load in the frame_tick cycle takes effect in the immediately following frame. rst pulse mid-SHOW forces anode inactive, seg off and the active set cleared with no clock edge required.
